// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: monitor FSM states and 640x480@60 mode constants.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a pix_en-gated detector for the edge into the active level.
module sync_edge_detect #(
    parameter bit ACTIVE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pix_en,
    input  logic sig_in,
    output logic level,
    output logic lead
);

    logic meta;
    logic sync;
    logic level_q;

    // Synchronizer resets to the inactive level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= ~ACTIVE_LEVEL;
            sync <= ~ACTIVE_LEVEL;
        end else begin
            meta <= sig_in;
            sync <= meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
        end else if (pix_en) begin
            level_q <= level;
        end
    end

    assign level = (sync == ACTIVE_LEVEL);
    assign lead  = pix_en & level & ~level_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// Recovers active-pixel coordinates from a sync/blank stream, measures line/frame
// length and declares lock after enough consecutive frames match the expected mode.
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL_EXP = H_TOTAL,
    parameter int unsigned V_TOTAL_EXP = V_TOTAL,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned CW          = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pix_en,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          hblank_in,
    input  logic          vblank_in,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic          de,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic          locked,
    output logic          timing_err,
    output logic          frame_start
);

    localparam int unsigned WDW       = (2 * H_TOTAL_EXP > 2) ? $clog2(2 * H_TOTAL_EXP) : 1;
    localparam int unsigned GW        = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST   = WDW'(2 * H_TOTAL_EXP - 1);
    localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_FRAMES - 1);
    localparam logic [CW-1:0]  H_EXP     = CW'(H_TOTAL_EXP);
    localparam logic [CW-1:0]  V_EXP     = CW'(V_TOTAL_EXP);

    logic hs_level, hs_lead;
    logic vs_level, vs_lead;
    logic hb_s, hb_lead;
    logic vb_s, vb_lead;
    logic unused_sync;

    sync_edge_detect #(.ACTIVE_LEVEL(SYNC_POL)) u_hsync (
        .clk     (clk),
        .reset_n (reset_n),
        .pix_en  (pix_en),
        .sig_in  (hsync_in),
        .level   (hs_level),
        .lead    (hs_lead)
    );

    sync_edge_detect #(.ACTIVE_LEVEL(SYNC_POL)) u_vsync (
        .clk     (clk),
        .reset_n (reset_n),
        .pix_en  (pix_en),
        .sig_in  (vsync_in),
        .level   (vs_level),
        .lead    (vs_lead)
    );

    sync_edge_detect #(.ACTIVE_LEVEL(1'b1)) u_hblank (
        .clk     (clk),
        .reset_n (reset_n),
        .pix_en  (pix_en),
        .sig_in  (hblank_in),
        .level   (hb_s),
        .lead    (hb_lead)
    );

    sync_edge_detect #(.ACTIVE_LEVEL(1'b1)) u_vblank (
        .clk     (clk),
        .reset_n (reset_n),
        .pix_en  (pix_en),
        .sig_in  (vblank_in),
        .level   (vb_s),
        .lead    (vb_lead)
    );

    assign unused_sync = ^{hs_level, vs_level, hb_lead, vb_lead};

    logic [CW-1:0]  h_cnt;
    logic [CW-1:0]  v_cnt;
    logic [WDW-1:0] wd_cnt;
    logic           line_bad;
    logic           de_next;
    logic [CW-1:0]  h_meas;
    logic [CW-1:0]  v_meas;
    logic           h_mis;
    logic           v_mis;
    logic           wd_to;

    assign de_next = ~hb_s & ~vb_s;
    assign h_meas  = (h_cnt == '1) ? h_cnt : h_cnt + CW'(1);
    assign v_meas  = v_cnt + CW'(1);
    assign h_mis   = hs_lead & (h_meas != H_EXP);
    assign v_mis   = (v_meas != V_EXP);
    // An hsync edge in the same pix_en restarts the watchdog instead of tripping it.
    assign wd_to   = pix_en & ~hs_lead & (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de          <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_total     <= '0;
            v_total     <= '0;
            wd_cnt      <= '0;
            line_bad    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vs_lead;
            if (pix_en) begin
                de <= de_next;

                if (hb_s)
                    x_pos <= '0;
                else if (de)
                    x_pos <= x_pos + CW'(1);

                if (vb_s)
                    y_pos <= '0;
                else if (de && !de_next)
                    y_pos <= y_pos + CW'(1);

                if (hs_lead) begin
                    h_total <= h_meas;
                    h_cnt   <= '0;
                end else if (h_cnt != '1) begin
                    h_cnt <= h_cnt + CW'(1);
                end

                // A coincident hsync edge is counted into v_total via v_cnt+1.
                if (vs_lead) begin
                    v_total <= v_meas;
                    v_cnt   <= '0;
                end else if (hs_lead) begin
                    v_cnt <= v_cnt + CW'(1);
                end

                if (hs_lead || wd_to)
                    wd_cnt <= '0;
                else
                    wd_cnt <= wd_cnt + WDW'(1);

                if (vs_lead)
                    line_bad <= 1'b0;
                else if (h_mis)
                    line_bad <= 1'b1;
            end
        end
    end

    mon_state_t    state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic          locked_d;
    logic          err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEARCH;
            good_q     <= '0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            locked     <= locked_d;
            timing_err <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        locked_d = locked;
        err_d    = 1'b0;
        if (pix_en) begin
            case (state_q)
                SEARCH: begin
                    if (vs_lead) begin
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                MEASURE: begin
                    if (wd_to) begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                        good_d  = '0;
                    end else if (vs_lead) begin
                        if (!v_mis && !line_bad && !h_mis) begin
                            if (good_q >= GOOD_LAST) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                good_d   = GW'(LOCK_FRAMES);
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (h_mis || wd_to || (vs_lead && v_mis)) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = SEARCH;
                        good_d   = '0;
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    good_d   = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down 32x16 mode (24x12 active).
module tb_vga_timing_monitor;

    localparam int H        = 32;
    localparam int V        = 16;
    localparam int H_ACT    = 24;
    localparam int V_ACT    = 12;
    localparam int HS_START = 26;
    localparam int HS_END   = 30;
    localparam int VS_LINE  = 13;
    localparam int CW       = 11;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pix_en;
    logic          hsync_in, vsync_in, hblank_in, vblank_in;
    logic [CW-1:0] x_pos, y_pos, h_total, v_total;
    logic          de, locked, timing_err, frame_start;

    vga_timing_monitor #(
        .H_TOTAL_EXP (H),
        .V_TOTAL_EXP (V),
        .SYNC_POL    (1'b0),
        .LOCK_FRAMES (2),
        .CW          (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_en      (pix_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hblank_in   (hblank_in),
        .vblank_in   (vblank_in),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .de          (de),
        .h_total     (h_total),
        .v_total     (v_total),
        .locked      (locked),
        .timing_err  (timing_err),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   v;
        int   h;
        logic de;
        int   x;
        int   y;
        logic fs;
    } probe_t;

    int   tests = 0;
    int   fails = 0;
    int   cur_v = 0, cur_h = 0;
    int   long_v = -1;
    logic hs_off = 1'b0;
    int   fs_cnt = 0, err_cnt = 0, lock_at_fs = -1;
    logic lock_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"},   32'(x_pos), 0);
        chk({tag, "_y"},   32'(y_pos), 0);
        chk({tag, "_de"},  32'(de), 0);
        chk({tag, "_ht"},  32'(h_total), 0);
        chk({tag, "_vt"},  32'(v_total), 0);
        chk({tag, "_lk"},  32'(locked), 0);
        chk({tag, "_err"}, 32'(timing_err), 0);
        chk({tag, "_fs"},  32'(frame_start), 0);
    endtask

    // One pixel: drive at a negedge, pix_en on the 4th clk, outputs settled on return.
    task automatic pix(input int pv, input int ph);
        logic hs_act, vs_act;
        hs_act = (ph >= HS_START) && (ph < HS_END) && !hs_off;
        vs_act = (pv == VS_LINE && ph >= HS_START) || (pv == VS_LINE + 1) ||
                 (pv == VS_LINE + 2 && ph < HS_START);
        hsync_in  = ~hs_act;
        vsync_in  = ~vs_act;
        hblank_in = (ph >= H_ACT);
        vblank_in = (pv >= V_ACT);
        repeat (3) @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        if (frame_start) fs_cnt++;
        if (timing_err) err_cnt++;
        if (locked && !lock_q) lock_at_fs = fs_cnt;
        lock_q = locked;
    endtask

    task automatic run_to(input int tv, input int th);
        int  n;
        int  pv, ph, len;
        bit  done;
        n    = 0;
        done = 0;
        while (!done) begin
            pv = cur_v;
            ph = cur_h;
            pix(pv, ph);
            len = (cur_v == long_v) ? H + 1 : H;
            cur_h++;
            if (cur_h >= len) begin
                cur_h = 0;
                cur_v = (cur_v + 1) % V;
            end
            if (pv == tv && ph == th) begin
                done = 1;
            end else begin
                n++;
                if (n > H * V + 2 * H) begin
                    tests++;
                    fails++;
                    $display("FAIL run_to_bound: position %0d,%0d not reached", tv, th);
                    done = 1;
                end
            end
        end
    endtask

    probe_t probes[10];

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int err_base, fs_base;

        probes[0] = '{0,  0,  1'b1, 0,  0,  1'b0};
        probes[1] = '{0,  1,  1'b1, 1,  0,  1'b0};
        probes[2] = '{0,  23, 1'b1, 23, 0,  1'b0};
        probes[3] = '{0,  24, 1'b0, 0,  1,  1'b0};
        probes[4] = '{1,  0,  1'b1, 0,  1,  1'b0};
        probes[5] = '{11, 23, 1'b1, 23, 11, 1'b0};
        probes[6] = '{11, 24, 1'b0, 0,  12, 1'b0};
        probes[7] = '{12, 0,  1'b0, 0,  0,  1'b0};
        probes[8] = '{13, 25, 1'b0, 0,  0,  1'b0};
        probes[9] = '{13, 26, 1'b0, 0,  0,  1'b1};

        reset_n   = 1'b0;
        pix_en    = 1'b0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        hblank_in = 1'b1;
        vblank_in = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Acquisition: SEARCH, then two good frames.
        run_to(VS_LINE, HS_START);
        chk("acq1_locked", 32'(locked), 0);
        chk("acq1_fs", 32'(frame_start), 1);
        run_to(VS_LINE, HS_START);
        chk("acq2_locked", 32'(locked), 0);
        chk("acq2_vtotal", 32'(v_total), V);
        run_to(VS_LINE, HS_START);
        chk("acq3_locked", 32'(locked), 1);
        chk("acq_lock_at_fs", 32'(lock_at_fs), 3);
        chk("acq_htotal", 32'(h_total), H);
        chk("acq_vtotal", 32'(v_total), V);
        chk("acq_no_err", 32'(err_cnt), 0);

        for (int i = 0; i < 10; i++) begin
            run_to(probes[i].v, probes[i].h);
            chk($sformatf("probe%0d_de", i), 32'(de), 32'(probes[i].de));
            chk($sformatf("probe%0d_x", i),  32'(x_pos), probes[i].x);
            chk($sformatf("probe%0d_y", i),  32'(y_pos), probes[i].y);
            chk($sformatf("probe%0d_fs", i), 32'(frame_start), 32'(probes[i].fs));
        end

        // pix_en held low while the sync inputs toggle.
        run_to(1, 5);
        chk("pre_freeze_x", 32'(x_pos), 5);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            {hsync_in, vsync_in, hblank_in, vblank_in} = 4'($urandom);
        end
        chk("freeze_x", 32'(x_pos), 5);
        chk("freeze_y", 32'(y_pos), 1);
        chk("freeze_de", 32'(de), 1);
        chk("freeze_htotal", 32'(h_total), H);
        chk("freeze_vtotal", 32'(v_total), V);
        chk("freeze_locked", 32'(locked), 1);
        run_to(1, 6);
        chk("post_freeze_x", 32'(x_pos), 6);
        chk("post_freeze_locked", 32'(locked), 1);

        // One line one pixel too long while locked.
        long_v = 2;
        run_to(3, HS_START - 1);
        chk("long_pre_err", 32'(timing_err), 0);
        chk("long_pre_locked", 32'(locked), 1);
        err_base = err_cnt;
        run_to(3, HS_START);
        chk("long_htotal", 32'(h_total), H + 1);
        chk("long_err", 32'(timing_err), 1);
        chk("long_locked", 32'(locked), 0);
        @(negedge clk);
        chk("long_err_width", 32'(timing_err), 0);
        long_v  = -1;
        fs_base = fs_cnt;
        run_to(VS_LINE, HS_START);
        chk("relock1_locked", 32'(locked), 0);
        run_to(VS_LINE, HS_START);
        chk("relock2_locked", 32'(locked), 0);
        run_to(VS_LINE, HS_START);
        chk("relock3_locked", 32'(locked), 1);
        chk("relock_at_fs", 32'(lock_at_fs), 32'(fs_base + 3));
        chk("relock_err_cnt", 32'(err_cnt), 32'(err_base + 1));
        chk("relock_htotal", 32'(h_total), H);

        // hsync held inactive: watchdog trips 2*H pix_en after the last edge.
        run_to(1, HS_START);
        hs_off = 1'b1;
        run_to(3, HS_START - 1);
        chk("wd_pre_err", 32'(timing_err), 0);
        chk("wd_pre_locked", 32'(locked), 1);
        err_base = err_cnt;
        run_to(3, HS_START);
        chk("wd_err", 32'(timing_err), 1);
        chk("wd_locked", 32'(locked), 0);
        hs_off = 1'b0;
        run_to(VS_LINE, HS_START);
        run_to(VS_LINE, HS_START);
        run_to(VS_LINE, HS_START);
        chk("wd_relock", 32'(locked), 1);
        chk("wd_err_cnt", 32'(err_cnt), 32'(err_base + 1));

        // Asynchronous reset mid-line, then reacquire.
        run_to(5, 10);
        chk("prereset_x", 32'(x_pos), 10);
        chk("prereset_y", 32'(y_pos), 5);
        chk("prereset_locked", 32'(locked), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset_n    = 1'b1;
        fs_cnt     = 0;
        lock_at_fs = -1;
        lock_q     = 1'b0;
        err_base   = err_cnt;
        run_to(VS_LINE, HS_START);
        chk("rst_acq1_locked", 32'(locked), 0);
        run_to(VS_LINE, HS_START);
        chk("rst_acq2_locked", 32'(locked), 0);
        run_to(VS_LINE, HS_START);
        chk("rst_acq3_locked", 32'(locked), 1);
        chk("rst_lock_at_fs", 32'(lock_at_fs), 3);
        chk("rst_no_err", 32'(err_cnt), 32'(err_base));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
Receive-side counterpart of the VGA timing generator. Samples an incoming hsync/vsync/hblank/vblank stream and recovers active-pixel coordinates and a data-enable. Measures line length and frame height, and declares lock once the measured timing matches the expected mode for a set number of consecutive frames. Sits downstream of the timing generator or a video input, and feeds the pixel/matrix display logic and status registers.

Parameters:
H_TOTAL_EXP, 800, expected pixels per line
V_TOTAL_EXP, 525, expected lines per frame
SYNC_POL, 0, sync active level (0 = active-low)
LOCK_FRAMES, 2, consecutive good frames required for lock
CW, 11, counter/coordinate width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_en  in  1  one-clk strobe per pixel; all sampling and counting occur only on pix_en=1
hsync_in  in  1  horizontal sync, polarity per SYNC_POL
vsync_in  in  1  vertical sync, polarity per SYNC_POL
hblank_in  in  1  horizontal blanking, active-high
vblank_in  in  1  vertical blanking, active-high
x_pos  out  CW  recovered active column
y_pos  out  CW  recovered active row
de  out  1  active-pixel indicator
h_total  out  CW  last measured pixels per line
v_total  out  CW  last measured lines per frame
locked  out  1  timing matches expected mode
timing_err  out  1  one-clk pulse on a detected mismatch or timeout
frame_start  out  1  one-clk pulse on the vsync leading edge

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (reset_n); the polarity and synchronicity are fixed.
- Reset values: all outputs 0, FSM in SEARCH, all internal counters 0.
- Inputs pass through a 2-flop synchronizer on clk. Edge-detect registers update only on pix_en.
- Leading edge: the previous sample was inactive and the current sample is active, both at SYNC_POL.
- Latency: input change to a registered output reaction takes 2 clk of synchronizer plus the next pix_en.
- de = ~hblank_s & ~vblank_s, registered on pix_en.
- x_pos: increments on each pix_en while de=1; cleared on any pix_en with hblank_s=1.
- y_pos: increments on the de falling edge (end of an active line); cleared on any pix_en with vblank_s=1.
- h_cnt: increments on each pix_en.
  - On an hsync leading edge: h_total <= h_cnt+1 and h_cnt <= 0.
  - h_cnt saturates at 2^CW-1.
- v_cnt: increments on each hsync leading edge.
  - On a vsync leading edge: v_total <= v_cnt+1, v_cnt <= 0, and frame_start pulses.
- Simultaneous hsync and vsync leading edges: process both.
  - v_total captures v_cnt+1 including the current line.
  - v_cnt restarts at 0.
- line_bad flag: set when a latched h_total differs from H_TOTAL_EXP. Cleared at each vsync leading edge, after that edge is evaluated.
- Watchdog: counts pix_en since the last hsync leading edge. Reaching 2*H_TOTAL_EXP forces an error event and restarts the watchdog count.
- FSM states: SEARCH, MEASURE, LOCKED; good_cnt ranges 0..LOCK_FRAMES.
  - SEARCH -> MEASURE on the first vsync leading edge; good_cnt <= 0.
  - MEASURE, on each vsync edge:
    - if v_cnt+1 == V_TOTAL_EXP and line_bad=0, good_cnt++;
    - otherwise good_cnt <= 0.
    - When good_cnt reaches LOCK_FRAMES: -> LOCKED, locked <= 1.
  - LOCKED: any of the following -> timing_err pulse, locked <= 0, state SEARCH:
    - an h_total mismatch;
    - a v_total mismatch at a vsync edge;
    - a watchdog timeout.
  - A watchdog timeout in MEASURE -> timing_err pulse, state SEARCH.
- timing_err never asserts in SEARCH.
- pix_en=0 freezes all counters, the edge detectors and the FSM. Only the synchronizer flops keep running.
- Reset asserted mid-frame clears all state immediately. Acquisition restarts from SEARCH.

Decomposition:
- Shared package vga_timing_pkg contains:
  - the FSM state enum (SEARCH/MEASURE/LOCKED);
  - the 640x480@60 mode constants (H_TOTAL 800, V_TOTAL 525, H_ACTIVE 640, V_ACTIVE 480), also used by the generator.
- One sub-module, sync_edge_detect: 2-flop synchronizer plus a pix_en-gated rising/falling edge output. Instantiated for hsync, vsync, hblank and vblank.

Test Plan:
- Nominal 800x525 stream, pix_en every 4th clk -> frame_start each frame; h_total=800, v_total=525; locked=1 at the 3rd vsync leading edge (SEARCH, then 2 good frames).
- Active region with locked=1:
  - first active pixel -> de=1, x_pos=0, y_pos=0;
  - last active pixel -> x_pos=639, y_pos=479;
  - during blanking -> de=0.
- While locked, inject one 801-pixel line -> h_total=801, single-clk timing_err, locked=0; relock after 1 SEARCH frame plus 2 good frames.
- Hold hsync_in inactive while locked -> timing_err at exactly 1600 pix_en after the last hsync edge; locked=0.
- Deassert pix_en for 100 clk while toggling all sync inputs -> x_pos, h_total, FSM and locked unchanged.
- Assert reset_n=0 mid-line -> all outputs 0 without waiting for a clk edge; after release, locked=1 again at the 3rd vsync edge.
